mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares a 4:1 multiplexer between four requesters (channels A, B, C, D).
- Owns the mux select.
  - Grants one requester at a time.
  - Bounds each grant's tenure so that no channel can starve the others.
- Sits in front of the 4-to-1 mux datapath. Produces a registered 2-bit select, a one-hot grant and a gated data output.

---
 rtl/mux4_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a 4:1 mux shared by channels A..D.
// Grants are registered; a contested owner is rotated out after MAX_HOLD cycles.
`timescale 1ns/1ps

module mux4_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [3:0]       gnt,
    output logic [1:0]       Sin,
    output logic             valid,
    output logic [WIDTH-1:0] out
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [1:0] last;
    logic [7:0] hold;

    logic [3:0] others;
    logic [3:0] scan_mask;
    logic [1:0] scan_base;
    logic [1:0] nxt;
    logic       owner_req;
    logic       at_limit;

    // First set bit of mask scanning p+1, p+2, p+3, p (mod 4); nearest wins.
    function automatic logic [1:0] rr_next(input logic [1:0] p, input logic [3:0] mask);
        logic [1:0] idx;
        rr_next = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (mask[idx]) rr_next = idx;
        end
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        others    = req & ~gnt;
        owner_req = |(req & gnt);
        at_limit  = (hold == HOLD_LAST);
        scan_base = last;
        scan_mask = req;
        // While granting, the owner is excluded; on a release its req bit is already 0.
        if (state == GRANT) begin
            scan_base = Sin;
            scan_mask = others;
        end
        nxt = rr_next(scan_base, scan_mask);
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            Sin   <= 2'd0;
            valid <= 1'b0;
            hold  <= 8'd0;
            last  <= 2'd3;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << nxt;
                        Sin   <= nxt;
                        valid <= 1'b1;
                        hold  <= 8'd0;
                    end
                end
                GRANT: begin
                    if (!owner_req || (at_limit && (|others))) begin
                        last <= Sin;
                        hold <= 8'd0;
                        if (|others) begin
                            gnt <= 4'b0001 << nxt;
                            Sin <= nxt;
                        end else begin
                            state <= IDLE;
                            gnt   <= 4'b0000;
                            valid <= 1'b0;
                        end
                    end else if (!at_limit) begin
                        hold <= hold + 8'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        out = '0;
        if (valid) begin
            case (Sin)
                2'd0:    out = A;
                2'd1:    out = B;
                2'd2:    out = C;
                default: out = D;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: a vector table plus hand-written preemption sequences,
// checked through an expected-result queue; a second instance runs with MAX_HOLD=1.
`timescale 1ns/1ps

module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req1;
    logic [3:0] a, b, c, d;
    logic [3:0] gnt, gnt1;
    logic [1:0] sin, sin1;
    logic       valid, valid1;
    logic [3:0] out, out1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .A(a), .B(b), .C(c), .D(d),
        .gnt(gnt), .Sin(sin), .valid(valid), .out(out)
    );

    mux4_rr_arbiter #(.WIDTH(4), .MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .A(a), .B(b), .C(c), .D(d),
        .gnt(gnt1), .Sin(sin1), .valid(valid1), .out(out1)
    );

    typedef struct {
        int         which;
        logic [3:0] gnt;
        logic [1:0] sin;
        logic       valid;
        logic [3:0] out;
        string      tag;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sin;
        logic       valid;
        string      tag;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] pick(input logic [1:0] s, input logic v);
        if (!v) return 4'h0;
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic drive(input int which, input logic r, input logic [3:0] q,
                         input logic [3:0] eg, input logic [1:0] es, input logic ev,
                         input string tag);
        exp_t e;
        rst = r;
        if (which == 0) req = q;
        else req1 = q;
        a = 4'($urandom());
        b = 4'($urandom());
        c = 4'($urandom());
        d = 4'($urandom());
        e.which = which;
        e.gnt   = eg;
        e.sin   = es;
        e.valid = ev;
        e.out   = pick(es, ev);
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            if (e.which == 0) begin
                check({e.tag, ".gnt"},   32'(gnt),   32'(e.gnt));
                check({e.tag, ".sin"},   32'(sin),   32'(e.sin));
                check({e.tag, ".valid"}, 32'(valid), 32'(e.valid));
                check({e.tag, ".out"},   32'(out),   32'(e.out));
            end else begin
                check({e.tag, ".gnt1"},   32'(gnt1),   32'(e.gnt));
                check({e.tag, ".sin1"},   32'(sin1),   32'(e.sin));
                check({e.tag, ".valid1"}, 32'(valid1), 32'(e.valid));
                check({e.tag, ".out1"},   32'(out1),   32'(e.out));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        req1 = 4'b0000;
        a = 4'h0; b = 4'h0; c = 4'h0; d = 4'h0;

        //          rst   req      gnt      sin   valid tag
        vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "rst0"};
        vecs[1]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "rst1"};
        vecs[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, "single_c"};
        vecs[3]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "rst_over_grant"};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, "all_a"};
        vecs[5]  = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1, "all_b"};
        vecs[6]  = '{1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, "all_c"};
        vecs[7]  = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, "all_d"};
        vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, "all_idle"};
        vecs[9]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, "grant_b"};
        vecs[10] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, "idle0"};
        vecs[11] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, "idle1"};
        vecs[12] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, "idle2"};
        vecs[13] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, "resume_d"};
        vecs[14] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, "idle_d"};
        vecs[15] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, "mid_a"};
        vecs[16] = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1, "mid_b"};
        vecs[17] = '{1'b0, 4'b1100, 4'b0100, 2'd2, 1'b1, "mid_c"};
        vecs[18] = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, "mid_c_h1"};
        vecs[19] = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, "mid_c_h2"};
        vecs[20] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "mid_rst"};
        vecs[21] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, "post_rst_a"};
        vecs[22] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, "drop_same_edge"};
        vecs[23] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, "idle_c"};

        foreach (vecs[i])
            drive(0, vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].sin, vecs[i].valid, vecs[i].tag);

        // Preemption: A owns 4 cycles against D, then D owns 4 cycles against A.
        drive(0, 1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, "pre_a0");
        for (int i = 0; i < 3; i++)
            drive(0, 1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1, $sformatf("pre_a%0d", i + 1));
        drive(0, 1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, "pre_d0");
        for (int i = 0; i < 3; i++)
            drive(0, 1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, $sformatf("pre_d%0d", i + 1));
        drive(0, 1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1, "pre_back_a");
        drive(0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "pre_idle");

        // Uncontested hold: B keeps the grant for all 20 cycles.
        for (int i = 0; i < 20; i++)
            drive(0, 1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, $sformatf("hold_b%0d", i));
        drive(0, 1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, "hold_idle");

        // MAX_HOLD=1: contested owners alternate every cycle.
        drive(1, 1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, "mh1_a");
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                drive(1, 1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, $sformatf("mh1_alt%0d", i));
            else
                drive(1, 1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, $sformatf("mh1_alt%0d", i));
        end
        for (int i = 0; i < 3; i++)
            drive(1, 1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, $sformatf("mh1_solo%0d", i));
        drive(1, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "mh1_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
